// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_rx
// Oversampling UART receiver for 8N1 frames (idle high, start 0, eight data
// bits LSB first, stop 1). The line is brought into the clk domain through a
// two-flop synchroniser. Each bit is sampled at its middle, counted in ticks
// of the external enable strobe. A good byte is presented with a one-cycle
// valid pulse. A bad stop bit raises a sticky framing error instead.
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   enable    in   oversample tick, OVERSAMPLE ticks per bit; nothing advances
//                  without it
//   data_in   in   asynchronous serial line, idle high
//   data_out  out  last correctly framed byte
//   valid     out  one-clk pulse when data_out has just been updated
//   busy      out  high whenever a frame is in progress
//   error     out  sticky framing error, cleared by the next start detection
//
// OVERSAMPLE must be even and at least 4.
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       busy,
  output logic       error
);

  localparam int SW = $clog2(OVERSAMPLE);
  // Tick index of the middle of the start bit, counted from detection
  localparam logic [SW-1:0] MID_CNT  = SW'(OVERSAMPLE / 2 - 1);
  // Tick index of the last tick in a full bit period
  localparam logic [SW-1:0] LAST_CNT = SW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state_reg, state_next;
  logic [SW-1:0]   s_cnt_reg, s_cnt_next;
  logic [2:0]      b_cnt_reg, b_cnt_next;
  logic [7:0]      shift_reg, shift_next;
  logic [7:0]      data_out_reg, data_out_next;
  logic            valid_reg, valid_next;
  logic            error_reg, error_next;
  logic            rx_prev_reg, rx_prev_next;
  logic            sync1_reg;
  logic            rx_reg;

  // Two-flop synchroniser. Both flops reset to the idle level so that reset
  // cannot fake a falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= 1'b1;
      rx_reg    <= 1'b1;
    end else begin
      sync1_reg <= data_in;
      rx_reg    <= sync1_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      s_cnt_reg    <= '0;
      b_cnt_reg    <= '0;
      shift_reg    <= '0;
      data_out_reg <= '0;
      valid_reg    <= 1'b0;
      error_reg    <= 1'b0;
      rx_prev_reg  <= 1'b1;
    end else begin
      state_reg    <= state_next;
      s_cnt_reg    <= s_cnt_next;
      b_cnt_reg    <= b_cnt_next;
      shift_reg    <= shift_next;
      data_out_reg <= data_out_next;
      valid_reg    <= valid_next;
      error_reg    <= error_next;
      rx_prev_reg  <= rx_prev_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    s_cnt_next    = s_cnt_reg;
    b_cnt_next    = b_cnt_reg;
    shift_next    = shift_reg;
    data_out_next = data_out_reg;
    valid_next    = 1'b0;
    error_next    = error_reg;
    rx_prev_next  = rx_prev_reg;

    if (enable) begin
      // Edge detection compares against the line as it was on the previous
      // tick, so a line that stays low never produces another start.
      rx_prev_next = rx_reg;
      case (state_reg)
        IDLE: begin
          if (rx_prev_reg && !rx_reg) begin
            state_next = START;
            s_cnt_next = '0;
            error_next = 1'b0;
          end
        end
        START: begin
          if (s_cnt_reg == MID_CNT) begin
            if (!rx_reg) begin
              state_next = DATA;
              s_cnt_next = '0;
              b_cnt_next = '0;
            end else begin
              // Line went back high before mid-start: treat it as a glitch
              state_next = IDLE;
            end
          end else begin
            s_cnt_next = s_cnt_reg + SW'(1);
          end
        end
        DATA: begin
          if (s_cnt_reg == LAST_CNT) begin
            shift_next = {rx_reg, shift_reg[7:1]};
            s_cnt_next = '0;
            if (b_cnt_reg == 3'd7) begin
              state_next = STOP;
            end else begin
              b_cnt_next = b_cnt_reg + 3'd1;
            end
          end else begin
            s_cnt_next = s_cnt_reg + SW'(1);
          end
        end
        STOP: begin
          if (s_cnt_reg == LAST_CNT) begin
            state_next = IDLE;
            if (rx_reg) begin
              data_out_next = shift_reg;
              valid_next    = 1'b1;
            end else begin
              error_next = 1'b1;
            end
          end else begin
            s_cnt_next = s_cnt_reg + SW'(1);
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign data_out = data_out_reg;
  assign valid    = valid_reg;
  assign error    = error_reg;
  assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_uart_rx
// Drives uart_rx with a tick-synchronous serial transmitter and checks the
// received bytes, the framing error flag and busy. Expected values come from
// constant vector records and from a frame-level model of the receiver:
// a frame with a good stop bit yields one valid carrying its byte, while a
// frame with a bad stop bit sets error and leaves data_out alone.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid;
  logic       busy;
  logic       error;

  logic       stall = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] got_q[$];

  uart_rx #(.OVERSAMPLE(OS)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .data_in  (data_in),
    .data_out (data_out),
    .valid    (valid),
    .busy     (busy),
    .error    (error)
  );

  always #5 clk = ~clk;

  // Tick strobe: one clk in four, held off while stall is set
  initial begin
    int div;
    div    = 0;
    enable = 1'b0;
    forever begin
      @(negedge clk);
      div    = (div + 1) % 4;
      enable = (div == 0) && !stall;
    end
  end

  // Collects every valid pulse and checks that none is wider than one clk
  initial begin
    logic valid_prev;
    valid_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (valid) begin
        got_q.push_back(data_out);
        n_cmp++;
        if (valid_prev) begin
          n_bad++;
          $display("FAIL valid_width: valid high 2 clks in a row, required 1");
        end
      end
      valid_prev = valid;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Waits for the next tick; returns 1 ns after that clock edge
  task automatic wait_tick();
    int guard;
    guard = 0;
    do begin
      @(posedge clk);
      guard++;
    end while (!enable && guard < 200);
    if (!enable) begin
      n_cmp++;
      n_bad++;
      $display("FAIL tick_timeout: no enable in %0d clks, required within 200", guard);
    end
    #1;
  endtask

  task automatic send_bit(input logic b, input int n);
    @(negedge clk);
    data_in = b;
    repeat (n) wait_tick();
  endtask

  // Whole frame; stall_bit >= 0 freezes ticks for 50 clk mid-way through that
  // data bit (transmitter and receiver both stall)
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int stall_bit);
    send_bit(1'b0, OS);
    check("busy_after_start", busy, 1);
    check("error_cleared_at_detect", error, 0);
    for (int k = 0; k < 8; k++) begin
      if (k == stall_bit) begin
        send_bit(d[k], OS / 2);
        stall = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        check("busy_during_stall", busy, 1);
        stall = 1'b0;
        repeat (OS / 2) wait_tick();
      end else begin
        send_bit(d[k], OS);
      end
    end
    send_bit(stop_bit, OS);
  endtask

  // Compares the number of collected valid pulses and, if one was expected,
  // the byte it carried; then empties the collection
  task automatic check_q(input string name, input int exp_n, input logic [7:0] exp_byte);
    check({name, "_valid_count"}, 32'(got_q.size()), 32'(exp_n));
    if (exp_n > 0 && got_q.size() > 0)
      check({name, "_valid_data"}, got_q[0], exp_byte);
    got_q.delete();
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    int         idle_bits;
    int         exp_valids;
    logic [7:0] exp_data;
    logic       exp_error;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [7:0] model_data;
    logic       model_err;

    vecs[0] = '{data: 8'hA5, stop_bit: 1'b1, idle_bits: 1, exp_valids: 1, exp_data: 8'hA5, exp_error: 1'b0};
    vecs[1] = '{data: 8'h00, stop_bit: 1'b1, idle_bits: 0, exp_valids: 1, exp_data: 8'h00, exp_error: 1'b0};
    vecs[2] = '{data: 8'hFF, stop_bit: 1'b1, idle_bits: 0, exp_valids: 1, exp_data: 8'hFF, exp_error: 1'b0};
    vecs[3] = '{data: 8'h80, stop_bit: 1'b1, idle_bits: 0, exp_valids: 1, exp_data: 8'h80, exp_error: 1'b0};
    vecs[4] = '{data: 8'h01, stop_bit: 1'b1, idle_bits: 1, exp_valids: 1, exp_data: 8'h01, exp_error: 1'b0};

    reset   = 1'b1;
    data_in = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_data_out", data_out, 8'h00);
    check("reset_valid", valid, 0);
    check("reset_busy", busy, 0);
    check("reset_error", error, 0);
    reset = 1'b0;
    send_bit(1'b1, 2 * OS);

    // Basic frame followed by back-to-back extremes
    for (int i = 0; i < 5; i++) begin
      send_frame(vecs[i].data, vecs[i].stop_bit, -1);
      check_q($sformatf("vec%0d", i), vecs[i].exp_valids, vecs[i].exp_data);
      check($sformatf("vec%0d_data_out", i), data_out, vecs[i].exp_data);
      check($sformatf("vec%0d_error", i), error, vecs[i].exp_error);
      check($sformatf("vec%0d_busy_end", i), busy, 0);
      if (vecs[i].idle_bits > 0) send_bit(1'b1, vecs[i].idle_bits * OS);
    end

    // Framing error, line held low, then a good frame
    send_frame(8'h3C, 1'b0, -1);
    check_q("ferr", 0, 8'h00);
    check("ferr_error", error, 1);
    check("ferr_data_hold", data_out, 8'h01);
    send_bit(1'b0, OS);
    check("ferr_low_no_rearm1", busy, 0);
    send_bit(1'b0, OS);
    check("ferr_low_no_rearm2", busy, 0);
    check("ferr_error_sticky", error, 1);
    check("ferr_data_hold2", data_out, 8'h01);
    send_bit(1'b1, OS);
    send_frame(8'h5A, 1'b1, -1);
    check_q("after_ferr", 1, 8'h5A);
    check("after_ferr_error", error, 0);
    check("after_ferr_data", data_out, 8'h5A);
    send_bit(1'b1, OS);

    // Glitch start: 3 ticks low
    send_bit(1'b0, 3);
    check("glitch_busy_high", busy, 1);
    send_bit(1'b1, OS);
    check("glitch_busy_low", busy, 0);
    check("glitch_error", error, 0);
    check_q("glitch", 0, 8'h00);
    send_frame(8'h11, 1'b1, -1);
    check_q("post_glitch", 1, 8'h11);
    check("post_glitch_data", data_out, 8'h11);
    send_bit(1'b1, OS);

    // Enable withheld in the middle of bit 4
    send_frame(8'hC3, 1'b1, 4);
    check_q("stall", 1, 8'hC3);
    check("stall_data", data_out, 8'hC3);
    check("stall_error", error, 0);
    send_bit(1'b1, OS);

    // Reset during bit 5 of 0x77
    send_bit(1'b0, OS);
    for (int k = 0; k < 5; k++) send_bit(1'(8'h77 >> k), OS);
    send_bit(1'b1, OS / 2);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_reset_data_out", data_out, 8'h00);
    check("mid_reset_valid", valid, 0);
    check("mid_reset_busy", busy, 0);
    check("mid_reset_error", error, 0);
    repeat (OS / 2) wait_tick();
    send_bit(1'b1, OS);
    send_bit(1'b0, OS);
    send_bit(1'b1, OS);
    check_q("mid_reset_remainder", 0, 8'h00);
    // Bit 7 (0) after bit 6 (1) is a genuine falling edge to the receiver, so
    // the abandoned tail is taken as a new start; everything it samples after
    // that is high, so it completes as 0xFF once the line idles.
    send_bit(1'b1, 12 * OS);
    check_q("mid_reset_tail", 1, 8'hFF);
    send_frame(8'h77, 1'b1, -1);
    check_q("fresh_77", 1, 8'h77);
    check("fresh_77_data", data_out, 8'h77);
    send_bit(1'b1, OS);

    // Random frames against the frame-level model
    model_data = 8'h77;
    model_err  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      logic [7:0] d;
      logic       sb;
      int         gap;
      d   = 8'($urandom_range(0, 255));
      sb  = ($urandom_range(0, 3) != 0);
      gap = $urandom_range(0, 2);
      // After a bad stop the line must return high before it can re-arm
      if (!sb && gap == 0) gap = 1;
      send_frame(d, sb, -1);
      if (sb) begin
        model_data = d;
        model_err  = 1'b0;
        check_q($sformatf("rnd%0d", i), 1, d);
      end else begin
        model_err = 1'b1;
        check_q($sformatf("rnd%0d", i), 0, 8'h00);
      end
      check($sformatf("rnd%0d_data_out", i), data_out, model_data);
      check($sformatf("rnd%0d_error", i), error, model_err);
      check($sformatf("rnd%0d_busy_end", i), busy, 0);
      if (gap > 0) send_bit(1'b1, gap * OS);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
